// File: rtl/dds_freq_meter.sv
// dds_freq_meter
// Gated frequency counter for a square wave such as a DDS phase-accumulator
// MSB. Rising edges of F_in are counted over a window of 2^GATE_LOG2 clk
// cycles. The count is scaled into an estimate of the tuning word that would
// produce that frequency:
//   K_est = edge_cnt << (32 - GATE_LOG2)
// F_in is asynchronous to clk, so it passes through a two-flop synchronizer
// before edge detection. Because of this synchronizer, no more than one rise
// can be seen every two clk cycles. The edge accumulator therefore needs only
// GATE_LOG2 bits. One spare bit is kept so that the arithmetic cannot wrap.

module dds_freq_meter #(
  parameter int GATE_LOG2 = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        F_in,
  input  logic        start,
  input  logic        cont,
  output logic        busy,
  output logic        valid,
  output logic [31:0] edge_cnt,
  output logic [31:0] K_est,
  output logic        no_signal
);

  // Accumulator width: the largest possible count is 2^(GATE_LOG2-1)+1,
  // so GATE_LOG2+1 bits is always enough.
  localparam int ACC_W = GATE_LOG2 + 1;

  // Scaling from edges per gate to a 32-bit tuning word.
  localparam int K_SHIFT = 32 - GATE_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  logic s1;
  logic s2;
  logic s3;
  logic rise;

  logic [GATE_LOG2-1:0] gate_cnt;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     acc_final;
  logic [31:0]          acc_final32;
  logic [31:0]          k_calc;
  logic                 gate_last;

  // Synchronize F_in into the clk domain.
  // Keep one extra delayed copy so that a rising edge can be detected.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= F_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  // The final gate cycle can also contain a rise. The result is therefore
  // registered from the accumulator plus this cycle's rise, so that the last
  // cycle of the window is not lost.
  assign acc_final   = acc + ACC_W'(rise);
  assign acc_final32 = 32'(acc_final);
  assign k_calc      = acc_final32 << K_SHIFT;
  assign gate_last   = (gate_cnt == '1);

  // Measurement FSM.
  // busy, valid and all the results are registered here, so they all change
  // together with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      valid     <= 1'b0;
      edge_cnt  <= '0;
      K_est     <= '0;
      no_signal <= 1'b0;
      gate_cnt  <= '0;
      acc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          // start and cont together are treated as a single request.
          if (start || cont) begin
            state    <= GATE;
            busy     <= 1'b1;
            gate_cnt <= '0;
            acc      <= '0;
          end
        end

        GATE: begin
          acc      <= acc_final;
          gate_cnt <= gate_cnt + GATE_LOG2'(1);
          if (gate_last) begin
            state     <= DONE;
            valid     <= 1'b1;
            edge_cnt  <= acc_final32;
            K_est     <= k_calc;
            no_signal <= (acc_final == '0);
          end
        end

        DONE: begin
          valid    <= 1'b0;
          gate_cnt <= '0;
          acc      <= '0;
          // In continuous mode the next gate starts immediately, and busy
          // stays high. Otherwise the FSM returns to IDLE, where start is
          // sampled again.
          if (cont) begin
            state <= GATE;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          valid    <= 1'b0;
          gate_cnt <= '0;
          acc      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_freq_meter.sv
// tb_dds_freq_meter
// Testbench for dds_freq_meter with GATE_LOG2 = 8, which gives a 256-cycle gate.
// A table of signal sources is applied one at a time. For each source, the
// expected result is pushed onto a scoreboard when the measurement starts.
// It is popped and compared when valid rises.
// Hand-written sequences then exercise continuous mode and an aborted gate.

module tb_dds_freq_meter;

  localparam int GL      = 8;
  localparam int LATENCY = 257;
  localparam int TIMEOUT = 600;

  localparam int SRC_LEVEL  = 0;
  localparam int SRC_SQUARE = 1;
  localparam int SRC_DDS    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        F_in;
  logic        start;
  logic        cont;
  logic        busy;
  logic        valid;
  logic [31:0] edge_cnt;
  logic [31:0] K_est;
  logic        no_signal;

  int total = 0;
  int bad   = 0;

  // Signal source state. The main test process changes it while the DUT is
  // idle.
  int          src_mode   = SRC_LEVEL;
  int          src_period = 16;
  logic [31:0] src_k      = 32'd0;
  logic        src_level  = 1'b0;
  logic [31:0] src_phase  = 32'd0;
  int          src_tick   = 0;

  logic watch_busy = 1'b0;
  int   busy_drops = 0;

  typedef struct {
    int          mode;
    int          period;
    logic [31:0] k;
    logic        level;
    int          exp_cnt;
    int          tol;
    logic        exp_nosig;
  } vec_t;

  typedef struct {
    int   cnt;
    int   tol;
    logic nosig;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];

  dds_freq_meter #(.GATE_LOG2(GL)) dut (
    .clk       (clk),
    .rst       (rst),
    .F_in      (F_in),
    .start     (start),
    .cont      (cont),
    .busy      (busy),
    .valid     (valid),
    .edge_cnt  (edge_cnt),
    .K_est     (K_est),
    .no_signal (no_signal)
  );

  always #5 clk = ~clk;

  // Generate F_in on the falling edge. The source is a constant level, a
  // square wave with an integer period, or the MSB of a DDS phase accumulator.
  initial begin
    F_in = 1'b0;
    forever begin
      @(negedge clk);
      case (src_mode)
        SRC_SQUARE: begin
          src_tick = (src_tick + 1) % src_period;
          F_in = (src_tick < src_period / 2);
        end
        SRC_DDS: begin
          src_phase = src_phase + src_k;
          F_in = src_phase[31];
        end
        default: F_in = src_level;
      endcase
    end
  end

  // In continuous mode, busy must never fall between gates.
  initial begin
    forever begin
      @(negedge clk);
      if (watch_busy && !busy) busy_drops++;
    end
  end

  task automatic checkRange(input string name, input longint actual,
                            input longint lo, input longint hi);
    total++;
    if (actual < lo || actual > hi) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h..0x%0h", name, actual, lo, hi);
    end
  endtask

  task automatic checkEq(input string name, input longint actual, input longint expected);
    checkRange(name, actual, expected, expected);
  endtask

  task automatic setSource(input vec_t v);
    src_mode   = v.mode;
    src_period = v.period;
    src_k      = v.k;
    src_level  = v.level;
    src_tick   = 0;
    src_phase  = 32'd0;
  endtask

  // Switch the source while the DUT is idle and let the synchronizer settle.
  // Push the expected result, then raise start for one cycle.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    setSource(v);
    repeat (12) @(negedge clk);
    e.cnt   = v.exp_cnt;
    e.tol   = v.tol;
    e.nosig = v.exp_nosig;
    sb.push_back(e);
    start = 1'b1;
  endtask

  // Count falling edges until valid is seen, with a bound on the wait.
  // start is dropped after the first edge, so a request lasts one cycle.
  task automatic waitValid(output int cycles);
    cycles = 0;
    while (cycles < TIMEOUT) begin
      @(negedge clk);
      start = 1'b0;
      cycles++;
      if (valid) break;
    end
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    longint lo;
    longint hi;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_scoreboard: got valid, want no pending result", tag);
    end else begin
      e  = sb.pop_front();
      lo = (e.cnt - e.tol < 0) ? 0 : longint'(e.cnt - e.tol);
      hi = longint'(e.cnt + e.tol);
      checkRange({tag, "_edge_cnt"}, edge_cnt, lo, hi);
      checkRange({tag, "_K_est"}, K_est, lo << (32 - GL), hi << (32 - GL));
      checkEq({tag, "_no_signal"}, no_signal, e.nosig);
    end
  endtask

  initial begin
    int cycles;
    int valids;

    vecs[0] = '{SRC_SQUARE, 16, 32'h0,         1'b0, 16,  1, 1'b0};
    vecs[1] = '{SRC_DDS,    0,  32'h0800_0000, 1'b0, 8,   1, 1'b0};
    vecs[2] = '{SRC_LEVEL,  0,  32'h0,         1'b0, 0,   0, 1'b1};
    vecs[3] = '{SRC_SQUARE, 2,  32'h0,         1'b0, 128, 1, 1'b0};
    vecs[4] = '{SRC_SQUARE, 8,  32'h0,         1'b0, 32,  1, 1'b0};
    vecs[5] = '{SRC_DDS,    0,  32'h2000_0000, 1'b0, 32,  1, 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    cont  = 1'b0;
    repeat (3) @(negedge clk);
    checkEq("reset_busy", busy, 0);
    checkEq("reset_valid", valid, 0);
    checkEq("reset_edge_cnt", edge_cnt, 0);
    checkEq("reset_K_est", K_est, 0);
    checkEq("reset_no_signal", no_signal, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single-shot measurements from the table.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      waitValid(cycles);
      checkEq($sformatf("vec%0d_latency", i), cycles, LATENCY);
      checkOutput($sformatf("vec%0d", i));
      @(negedge clk);
      checkEq($sformatf("vec%0d_valid_width", i), valid, 0);
      checkEq($sformatf("vec%0d_busy_after", i), busy, 0);
    end

    // Continuous mode: back-to-back gates, valid every 257 cycles, busy held.
    setSource(vecs[0]);
    repeat (12) @(negedge clk);
    cont = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sb.push_back('{16, 1, 1'b0});
      waitValid(cycles);
      watch_busy = 1'b1;
      checkEq($sformatf("cont%0d_period", k), cycles, LATENCY);
      checkOutput($sformatf("cont%0d", k));
    end
    watch_busy = 1'b0;
    cont = 1'b0;
    @(negedge clk);
    checkEq("cont_busy_drops", busy_drops, 0);
    checkEq("cont_stop_busy", busy, 0);
    checkEq("cont_scoreboard_empty", sb.size(), 0);

    // Aborted gate: a second start during the gate is ignored, and a reset
    // late in the gate discards the measurement.
    repeat (8) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkEq("abort_busy_mid_gate", busy, 1);
    repeat (99) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkEq("abort_busy", busy, 0);
    checkEq("abort_valid", valid, 0);
    checkEq("abort_edge_cnt", edge_cnt, 0);
    checkEq("abort_K_est", K_est, 0);
    checkEq("abort_no_signal", no_signal, 0);
    rst = 1'b0;
    valids = 0;
    repeat (300) begin
      @(negedge clk);
      if (valid) valids++;
    end
    checkEq("abort_no_valid", valids, 0);
    checkEq("abort_idle_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
